mul_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the EX stage alongside the single-cycle ALU. The unit accepts one operation at a time through a start/busy handshake and reports completion with a one-cycle done pulse. The pipeline reads HI/LO directly for MFHI/MFLO and stalls while the unit is busy.

---
 rtl/mips_funct_pkg.sv | 45 ++++
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_funct_pkg.sv
// Shared MIPS R-type funct codes for the ALU and the multiply/divide unit.
// Also provides a decode helper for the multi-cycle mul/div subset.
package mips_funct_pkg;

  localparam int unsigned FUNCT_W = 6;

  // Shift operations
  localparam logic [FUNCT_W-1:0] FUNCT_SLL   = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL   = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA   = 6'b000011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV  = 6'b000111;

  // HI/LO moves
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;

  // Multiply / divide
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  // Single-cycle ALU operations
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR   = 6'b100110;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU  = 6'b101011;

  // True for the four codes that run through the iterative datapath.
  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO.
// Executes MULT/MULTU/DIV/DIVU (34-cycle latency) and MTHI/MTLO (1 cycle).
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_start, i_func     issue request and MIPS funct code
//   i_op1, i_op2        rs / rt operands
//   o_busy              operation in progress (decoded from state)
//   o_done              one-cycle completion pulse, HI/LO valid same cycle
//   o_hi, o_lo          HI/LO registers
module mul_div_unit
  import mips_funct_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [FUNCT_W-1:0] i_func,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned MAG_W  = WIDTH + 1;
  localparam int unsigned SUM_W  = WIDTH + 2;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              is_div;
  logic              neg_res;
  logic              neg_rem;
  logic [MAG_W-1:0]  acc;       // partial product high half / partial remainder
  logic [WIDTH-1:0]  q;         // multiplier bits / dividend-then-quotient bits
  logic [MAG_W-1:0]  opb;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0]  dividend;  // original i_op1, returned as HI on divide by zero

  logic              is_idle;
  logic              accept_md;
  logic              wr_hi;
  logic              wr_lo;
  logic              in_fix;

  logic              op_signed;
  logic              op_div;
  logic [WIDTH-1:0]  mag1;
  logic [WIDTH-1:0]  mag2;

  logic [MAG_W-1:0]  rem_shift;
  logic [SUM_W-1:0]  add_a;
  logic [SUM_W-1:0]  add_b;
  logic [SUM_W-1:0]  sum;

  logic [PROD_W-1:0] prod;
  logic [WIDTH-1:0]  res_hi;
  logic [WIDTH-1:0]  res_lo;

  // Request decode; only IDLE accepts anything
  assign is_idle   = (state == ST_IDLE);
  assign accept_md = i_start && is_idle && is_muldiv(i_func);
  assign wr_hi     = i_start && is_idle && (i_func == FUNCT_MTHI);
  assign wr_lo     = i_start && is_idle && (i_func == FUNCT_MTLO);

  // Operand magnitudes; negating in WIDTH bits then zero-extending keeps |-2^31| = 2^31
  assign op_signed = (i_func == FUNCT_MULT) || (i_func == FUNCT_DIV);
  assign op_div    = (i_func == FUNCT_DIV)  || (i_func == FUNCT_DIVU);
  assign mag1      = (op_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
  assign mag2      = (op_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_md)       state_nxt = ST_CALC;
      ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
      ST_FIX:                       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_busy = 1'b0;
    in_fix = 1'b0;
    case (state)
      ST_CALC: o_busy = 1'b1;
      ST_FIX: begin
        o_busy = 1'b1;
        in_fix = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared adder: add multiplicand when the multiplier LSB is set, or trial-subtract the divisor
  always_comb begin
    rem_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    if (is_div) begin
      add_a = {1'b0, rem_shift};
      add_b = ~{1'b0, opb};
    end else begin
      add_a = {1'b0, acc};
      add_b = q[0] ? {1'b0, opb} : '0;
    end
    sum = add_a + add_b + SUM_W'(is_div);
  end

  // Iterative datapath; contents are don't-care outside an operation, so no reset
  always_ff @(posedge i_clk) begin
    if (accept_md) begin
      cnt      <= '0;
      is_div   <= op_div;
      acc      <= '0;
      q        <= op_div ? mag1 : mag2;
      opb      <= op_div ? {1'b0, mag2} : {1'b0, mag1};
      neg_res  <= op_signed && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
      neg_rem  <= op_signed && i_op1[WIDTH-1];
      dividend <= i_op1;
    end else if (state == ST_CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        // Sign bit of the trial difference set means the divisor did not fit: restore
        if (sum[SUM_W-1]) begin
          acc <= rem_shift;
          q   <= {q[WIDTH-2:0], 1'b0};
        end else begin
          acc <= sum[MAG_W-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc <= sum[SUM_W-1:1];
        q   <= {sum[0], q[WIDTH-1:1]};
      end
    end
  end

  // Sign correction and final HI/LO selection, consumed in FIX
  always_comb begin
    prod   = {acc[WIDTH-1:0], q};
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      if (opb == '0) begin
        res_hi = dividend;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        res_lo = neg_res ? -q : q;
      end
    end else begin
      if (neg_res) begin
        prod = -prod;
      end
      res_hi = prod[PROD_W-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Architectural HI/LO and completion pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hi   <= '0;
      o_lo   <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= in_fix;
      if (in_fix) begin
        o_hi <= res_hi;
        o_lo <= res_lo;
      end else begin
        if (wr_hi) o_hi <= i_op1;
        if (wr_lo) o_lo <= i_op1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected {HI,LO}
// pushed at issue and compared on each o_done pulse.
module tb_mul_div_unit;
  import mips_funct_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [5:0]  i_func;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int          total;
  int          bad;
  logic [63:0] exp_q[$];
  logic [63:0] prev_hilo;

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_func  (i_func),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit integer arithmetic, result packed as {HI, LO}
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q64, r64;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      FUNCT_MULT:  return 64'(sa * sb);
      FUNCT_MULTU: return ua * ub;
      FUNCT_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q64 = sa / sb;
        r64 = sa % sb;
        return {r64[31:0], q64[31:0]};
      end
      FUNCT_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_func  = f;
    i_op1   = a;
    i_op2   = b;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 60) begin
      tick();
      lat++;
    end
    if (!o_done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat;
    exp_q.push_back(model(f, a, b));
    drive(f, a, b);
    wait_done(lat);
    check("latency", 64'(lat), 64'd33);
  endtask

  // Scoreboard compare on done; HI/LO must not move while busy
  always @(negedge i_clk) begin
    logic [63:0] e;
    if (o_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {o_hi, o_lo}, e);
      end
    end
    if (o_busy) check("hilo_stable", {o_hi, o_lo}, prev_hilo);
    prev_hilo = {o_hi, o_lo};
  end

  initial begin
    int lat;
    logic [5:0]  ops[4];
    logic [31:0] a, b;
    total   = 0;
    bad     = 0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_func  = 6'd0;
    i_op1   = 32'd0;
    i_op2   = 32'd0;
    ops[0]  = FUNCT_MULT;
    ops[1]  = FUNCT_MULTU;
    ops[2]  = FUNCT_DIV;
    ops[3]  = FUNCT_DIVU;
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_hilo", {o_hi, o_lo}, 64'd0);

    // MULTU max x max with exact busy window
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    drive(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 33; k++) begin
      check("busy_window", 64'(o_busy), 64'd1);
      check("no_early_done", 64'(o_done), 64'd0);
      tick();
    end
    check("busy_cleared", 64'(o_busy), 64'd0);
    check("done_pulse", 64'(o_done), 64'd1);
    check("multu_max", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("done_one_cycle", 64'(o_done), 64'd0);

    // Directed signed / boundary cases
    run_md(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_md(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_by_m1", {o_hi, o_lo}, 64'h0000_0000_8000_0000);
    run_md(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_sq", {o_hi, o_lo}, 64'h4000_0000_0000_0000);
    run_md(FUNCT_DIV, 32'hFFFF_FFFB, 32'd0);
    check("div_neg_by0", {o_hi, o_lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    run_md(FUNCT_DIVU, 32'd5, 32'd0);
    check("divu_by0", {o_hi, o_lo}, 64'h0000_0005_FFFF_FFFF);

    // Starts while busy are ignored; a start in the done cycle is accepted
    exp_q.push_back(model(FUNCT_MULT, 32'd7, 32'hFFFF_FFF7));
    drive(FUNCT_MULT, 32'd7, 32'hFFFF_FFF7);
    repeat (4) tick();
    drive(FUNCT_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_ignored", 64'(o_hi), 64'd5);
    repeat (4) tick();
    drive(FUNCT_DIVU, 32'd100, 32'd7);
    wait_done(lat);
    check("mult_after_ignored", 64'(lat), 64'd23);
    check("mult_collide", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFC1);
    exp_q.push_back(model(FUNCT_DIVU, 32'd100, 32'd7));
    drive(FUNCT_DIVU, 32'd100, 32'd7);
    check("accept_in_done_cycle", 64'(o_busy), 64'd1);
    wait_done(lat);
    check("latency_b2b", 64'(lat), 64'd33);

    // Unlisted funct is ignored
    drive(FUNCT_ADD, 32'd1, 32'd2);
    check("bad_funct", 64'(o_busy), 64'd0);

    // MTHI then MTLO back-to-back
    i_start = 1'b1;
    i_func  = FUNCT_MTHI;
    i_op1   = 32'h0000_1234;
    tick();
    check("mthi_hi", 64'(o_hi), 64'h1234);
    i_func  = FUNCT_MTLO;
    i_op1   = 32'h0000_ABCD;
    tick();
    i_start = 1'b0;
    check("mtlo_hilo", {o_hi, o_lo}, 64'h0000_1234_0000_ABCD);
    check("mt_no_done", 64'(o_done), 64'd0);

    // Reset wins over a simultaneous start
    i_rst = 1'b1;
    drive(FUNCT_MULTU, 32'd9, 32'd9);
    i_rst = 1'b0;
    check("rst_vs_start", 64'(o_busy), 64'd0);

    // Reset during CALC discards the operation
    drive(FUNCT_MULTU, 32'd1000, 32'd1000);
    repeat (9) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_hilo", {o_hi, o_lo}, 64'd0);
    repeat (40) tick();
    run_md(FUNCT_MULTU, 32'd2, 32'd3);
    check("multu_2x3", {o_hi, o_lo}, 64'd6);

    // Random operands across all four operations
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = $urandom;
        b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        run_md(ops[j], a, b);
      end
    end

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
